unified_mem_responder: RTL and testbench

- Synthesizable responder for the pipelined MIPS datapath's unified memory interface.
- Serves combinational reads and synchronous writes on one word-addressed array: instruction region low, data region high.
- Sequences one run: image load → core run → halt (stopf or cycle watchdog) → serial dump of the whole array.
- Replaces the simulation-only memory model, so the core can run on hardware or under a pure RTL bench.

---
 rtl/unified_mem_responder_pkg.sv | 21 ++
 rtl/unified_mem_responder_mem_array.sv | 28 ++
 rtl/unified_mem_responder.sv | 152 +++++++++++++++
 tb/tb_unified_mem_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_responder_pkg.sv
// Shared types and defaults for the unified memory responder.
// Holds the run-sequencing state enum and the word-index width helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEF_DEPTH      = 64;
    localparam int DEF_IMEM_WORDS = 32;
    localparam int DEF_MAX_CYCLES = 500;
    localparam int DEF_CNT_W      = 16;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/unified_mem_responder_mem_array.sv
// Word array with one synchronous write port and two combinational read ports.
// Contents are deliberately not reset so an image survives a responder reset.
module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] core_raddr_i,
    output logic [31:0]   core_rdata_o,
    input  logic [AW-1:0] dump_raddr_i,
    output logic [31:0]   dump_rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i && (32'(waddr_i) < 32'(DEPTH))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign core_rdata_o = mem_q[core_raddr_i];
    assign dump_rdata_o = mem_q[dump_raddr_i];

endmodule

// File: rtl/unified_mem_responder.sv
// Memory responder for the pipelined MIPS core: image load, run, halt, serial dump.
// Reads are combinational in every state; writes land on the clock edge.
module unified_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              memadd,
    input  logic [31:0]              outdata,
    input  logic                     writeDataEN,
    input  logic                     stopf,
    output logic [31:0]              memdata,
    output logic                     core_reset,
    input  logic                     ld_valid,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    input  logic                     start,
    output logic                     dump_valid,
    output logic [$clog2(DEPTH)-1:0] dump_addr,
    output logic [31:0]              dump_data,
    output logic                     done,
    output logic                     timeout,
    output logic                     wr_fault,
    output logic                     addr_fault
);

    localparam int AW = $clog2(DEPTH);

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  dump_addr_q, dump_addr_d;
    logic           timeout_q, timeout_d;
    logic           wr_fault_q, wr_fault_d;
    logic           addr_fault_q, addr_fault_d;

    logic [29:0]    idx;
    logic           in_range;
    logic           in_imem;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;
    logic [31:0]    core_rdata;
    logic           unused_byte_bits;

    // Full-width compare: high address bits must not alias into the array.
    assign idx              = memadd[31:2];
    assign in_range         = ({2'b00, idx} < 32'(DEPTH));
    assign in_imem          = ({2'b00, idx} < 32'(IMEM_WORDS));
    assign unused_byte_bits = ^memadd[1:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dump_addr_d  = dump_addr_q;
        timeout_d    = timeout_q;
        wr_fault_d   = wr_fault_q;
        addr_fault_d = addr_fault_q;
        mem_we       = 1'b0;
        mem_waddr    = ld_addr;
        mem_wdata    = ld_data;

        case (state_q)
            ST_LOAD: begin
                mem_we = ld_valid;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (!in_range) begin
                    addr_fault_d = 1'b1;
                end
                if (writeDataEN && in_range) begin
                    if (in_imem) begin
                        wr_fault_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = idx[AW-1:0];
                        mem_wdata = outdata;
                    end
                end
                if (stopf) begin
                    state_d = ST_DUMP;
                end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d   = ST_DUMP;
                    timeout_d = 1'b1;
                end
            end
            ST_DUMP: begin
                if (dump_addr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    dump_addr_d = dump_addr_q + 1'b1;
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            dump_addr_q  <= '0;
            timeout_q    <= 1'b0;
            wr_fault_q   <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dump_addr_q  <= dump_addr_d;
            timeout_q    <= timeout_d;
            wr_fault_q   <= wr_fault_d;
            addr_fault_q <= addr_fault_d;
        end
    end

    // Gating with reset keeps an edge that coincides with reset from writing.
    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk          (clk),
        .we_i         (mem_we & ~reset),
        .waddr_i      (mem_waddr),
        .wdata_i      (mem_wdata),
        .core_raddr_i (idx[AW-1:0]),
        .core_rdata_o (core_rdata),
        .dump_raddr_i (dump_addr_q),
        .dump_rdata_o (dump_data)
    );

    assign memdata    = in_range ? core_rdata : 32'h0;
    assign core_reset = (state_q != ST_RUN);
    assign dump_valid = (state_q == ST_DUMP);
    assign done       = (state_q == ST_DONE);
    assign dump_addr  = dump_addr_q;
    assign timeout    = timeout_q;
    assign wr_fault   = wr_fault_q;
    assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench for unified_mem_responder against a word-array reference model.
module tb_unified_mem_responder;

    localparam int DEPTH = 64;
    localparam int IMEM  = 32;
    localparam int MAXC  = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memadd, outdata, memdata, ld_data, dump_data;
    logic        writeDataEN, stopf, core_reset, ld_valid, start;
    logic        dump_valid, done, timeout, wr_fault, addr_fault;
    logic [5:0]  ld_addr, dump_addr;

    int checks = 0;
    int fails  = 0;

    logic [31:0] model [DEPTH];
    bit m_wf, m_af;

    always #5 clk = ~clk;

    unified_mem_responder dut (
        .clk(clk), .reset(reset), .memadd(memadd), .outdata(outdata),
        .writeDataEN(writeDataEN), .stopf(stopf), .memdata(memdata),
        .core_reset(core_reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .done(done),
        .timeout(timeout), .wr_fault(wr_fault), .addr_fault(addr_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] i;
        i = {2'b00, a[31:2]};
        return (i < DEPTH) ? model[i[5:0]] : 32'h0;
    endfunction

    // Applies one RUN cycle of core traffic to the reference model.
    function automatic void ref_core_cycle(input logic [31:0] a, input logic [31:0] d, input bit we);
        logic [31:0] i;
        i = {2'b00, a[31:2]};
        if (i >= DEPTH) m_af = 1'b1;
        else if (we && i < IMEM) m_wf = 1'b1;
        else if (we) model[i[5:0]] = d;
    endfunction

    task automatic idle_inputs();
        memadd = 32'h0; outdata = 32'h0; writeDataEN = 1'b0; stopf = 1'b0;
        ld_valid = 1'b0; ld_addr = 6'd0; ld_data = 32'h0; start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        checks++;
        if ({core_reset, dump_valid, done, timeout, wr_fault, addr_fault} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 100000",
                     {core_reset, dump_valid, done, timeout, wr_fault, addr_fault});
        end
        checks++;
        if (dump_addr !== 6'd0) begin
            fails++;
            $display("FAIL reset_dump_addr: got %0d expected 0", dump_addr);
        end
        tick();
        reset = 1'b0;
        m_wf = 1'b0; m_af = 1'b0;
        tick();
    endtask

    task automatic test_load();
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 6'(i);
            ld_data  = (i == 0) ? 32'h2008_0005 : (i == 40) ? 32'hDEAD_BEEF : $urandom;
            model[i] = ld_data;
            tick();
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            memadd = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
            #1;
            checks++;
            if (memdata !== ref_read(memadd)) begin
                fails++;
                $display("FAIL load_read addr=%h: got %h expected %h", memadd, memdata, ref_read(memadd));
            end
        end
        memadd = 32'h100;
        tick();
        checks++;
        if (memdata !== 32'h0 || addr_fault !== 1'b0) begin
            fails++;
            $display("FAIL load_oob_read: got data %h fault %b expected 0 0", memdata, addr_fault);
        end
        memadd   = 32'h0;
        ld_valid = 1'b1; ld_addr = 6'd5; ld_data = $urandom; start = 1'b1;
        model[5] = ld_data;
        #1;
        checks++;
        if (core_reset !== 1'b1) begin
            fails++;
            $display("FAIL core_reset_before_start: got %b expected 1", core_reset);
        end
        tick();
        ld_valid = 1'b0; start = 1'b0;
        checks++;
        if (core_reset !== 1'b0) begin
            fails++;
            $display("FAIL core_reset_after_start: got %b expected 0", core_reset);
        end
        memadd = 32'h14;
        #1;
        checks++;
        if (memdata !== model[5]) begin
            fails++;
            $display("FAIL load_with_start: got %h expected %h", memdata, model[5]);
        end
        memadd = 32'hA0;
        #1;
        checks++;
        if (memdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL read_A0: got %h expected deadbeef", memdata);
        end
    endtask

    task automatic test_data_write();
        memadd = 32'h84; outdata = 32'h1234_5678; writeDataEN = 1'b1;
        ref_core_cycle(memadd, outdata, 1'b1);
        tick();
        writeDataEN = 1'b0;
        #1;
        checks++;
        if (memdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL data_write_84: got %h expected 12345678", memdata);
        end
        memadd = 32'h86;
        #1;
        checks++;
        if (memdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL data_write_86: got %h expected 12345678", memdata);
        end
    endtask

    task automatic test_random_rw();
        logic [31:0] a;
        logic [31:0] d;
        bit we;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                a = 32'h1000_0000 | ($urandom_range(0, DEPTH - 1) << 2);
            else
                a = ($urandom_range(0, 71) << 2) | $urandom_range(0, 3);
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            memadd = a; outdata = d; writeDataEN = we;
            #1;
            checks++;
            if (memdata !== ref_read(a)) begin
                fails++;
                $display("FAIL rand_read addr=%h: got %h expected %h", a, memdata, ref_read(a));
            end
            ref_core_cycle(a, d, we);
            tick();
            checks++;
            if ({wr_fault, addr_fault} !== {m_wf, m_af}) begin
                fails++;
                $display("FAIL rand_flags addr=%h: got %b expected %b", a, {wr_fault, addr_fault}, {m_wf, m_af});
            end
        end
        writeDataEN = 1'b0;
        memadd = 32'h0;
    endtask

    task automatic test_protect();
        memadd = 32'h10; outdata = ~model[4]; writeDataEN = 1'b1;
        ref_core_cycle(memadd, outdata, 1'b1);
        tick();
        memadd = 32'h100; outdata = ~model[0]; writeDataEN = 1'b1;
        ref_core_cycle(memadd, outdata, 1'b1);
        tick();
        writeDataEN = 1'b0;
        #1;
        checks++;
        if (memdata !== 32'h0) begin
            fails++;
            $display("FAIL oob_read_100: got %h expected 0", memdata);
        end
        checks++;
        if ({wr_fault, addr_fault} !== 2'b11) begin
            fails++;
            $display("FAIL protect_flags: got %b expected 11", {wr_fault, addr_fault});
        end
        memadd = 32'h10;
        #1;
        checks++;
        if (memdata !== model[4]) begin
            fails++;
            $display("FAIL imem_unchanged: got %h expected %h", memdata, model[4]);
        end
        memadd = 32'h0;
        #1;
        checks++;
        if (memdata !== 32'h2008_0005) begin
            fails++;
            $display("FAIL no_alias_word0: got %h expected 20080005", memdata);
        end
    endtask

    task automatic test_halt_with_write();
        int n;
        memadd = 32'h90; outdata = 32'h0000_00AA; writeDataEN = 1'b1; stopf = 1'b1;
        ref_core_cycle(memadd, outdata, 1'b1);
        tick();
        writeDataEN = 1'b0; stopf = 1'b0; memadd = 32'h0;
        checks++;
        if ({dump_valid, core_reset} !== 2'b11) begin
            fails++;
            $display("FAIL dump_entry: got %b expected 11", {dump_valid, core_reset});
        end
        n = 0;
        while (dump_valid && n < 100) begin
            checks++;
            if (dump_addr !== 6'(n) || dump_data !== model[n % DEPTH]) begin
                fails++;
                $display("FAIL dump_word %0d: got addr %0d data %h expected data %h",
                         n, dump_addr, dump_data, model[n % DEPTH]);
            end
            n++;
            tick();
        end
        checks++;
        if (n !== DEPTH) begin
            fails++;
            $display("FAIL dump_length: got %0d expected %0d", n, DEPTH);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, core_reset, dump_valid, timeout} !== 4'b1100) begin
            fails++;
            $display("FAIL done_state: got %b expected 1100", {done, core_reset, dump_valid, timeout});
        end
        memadd = 32'h90;
        #1;
        checks++;
        if (memdata !== 32'hAA) begin
            fails++;
            $display("FAIL done_read_90: got %h expected aa", memdata);
        end
    endtask

    task automatic test_watchdog();
        int n;
        idle_inputs();
        reset = 1'b1; #2; reset = 1'b0;
        tick();
        checks++;
        if ({timeout, wr_fault, addr_fault, done} !== 4'b0000) begin
            fails++;
            $display("FAIL sticky_clear: got %b expected 0000", {timeout, wr_fault, addr_fault, done});
        end
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!core_reset && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (n !== MAXC || timeout !== 1'b1 || dump_valid !== 1'b1) begin
            fails++;
            $display("FAIL watchdog: got cycles %0d timeout %b dump %b expected %0d 1 1",
                     n, timeout, dump_valid, MAXC);
        end
        reset = 1'b1; #2; reset = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < MAXC - 1; i++) tick();
        checks++;
        if (core_reset !== 1'b0) begin
            fails++;
            $display("FAIL still_running_at_499: got core_reset %b expected 0", core_reset);
        end
        stopf = 1'b1; tick(); stopf = 1'b0;
        checks++;
        if ({dump_valid, timeout} !== 2'b10) begin
            fails++;
            $display("FAIL stopf_beats_watchdog: got %b expected 10", {dump_valid, timeout});
        end
    endtask

    task automatic test_reset_mid_dump();
        int n;
        n = 0;
        while (dump_addr !== 6'd20 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (dump_addr !== 6'd20 || dump_valid !== 1'b1) begin
            fails++;
            $display("FAIL reach_dump_20: got addr %0d valid %b expected 20 1", dump_addr, dump_valid);
        end
        #2;
        ld_valid = 1'b1; ld_addr = 6'd7; ld_data = ~model[7];
        reset = 1'b1;
        #1;
        checks++;
        if ({core_reset, dump_valid, done, timeout, wr_fault, addr_fault} !== 6'b100000 || dump_addr !== 6'd0) begin
            fails++;
            $display("FAIL async_reset: got %b addr %0d expected 100000 addr 0",
                     {core_reset, dump_valid, done, timeout, wr_fault, addr_fault}, dump_addr);
        end
        tick();
        ld_valid = 1'b0;
        reset = 1'b0;
        memadd = 32'h1C;
        #1;
        checks++;
        if (memdata !== model[7]) begin
            fails++;
            $display("FAIL no_write_on_reset_edge: got %h expected %h", memdata, model[7]);
        end
        for (int k = 0; k < 6; k++) begin
            memadd = $urandom_range(0, DEPTH - 1) << 2;
            #1;
            checks++;
            if (memdata !== ref_read(memadd)) begin
                fails++;
                $display("FAIL preserved addr=%h: got %h expected %h", memadd, memdata, ref_read(memadd));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_data_write();
        test_random_rw();
        test_protect();
        test_halt_with_write();
        test_watchdog();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
